// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter that serialises write/read transactions into RAM command words.
// Optional RD_WAIT timeout (rdata=8'hFF plus an err pulse) is enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [7:0]           wdata0,
   input  logic [7:0]           wdata1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [7:0]           rdata0,
   output logic [7:0]           rdata1,
   output logic                 ram_rx_valid,
   output logic [ADDR_SIZE+1:0] ram_din,
   input  logic                 ram_tx_valid,
   input  logic [7:0]           ram_dout,
   output logic                 busy
`ifdef RAM_ARB_TIMEOUT_EN
   ,
   output logic                 err
`endif
);

   localparam int DIN_W = ADDR_SIZE + 2;

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_WAIT, DONE
   } state_t;

   state_t               state, next_state;
   logic                 grant, grant_n;
   logic                 last_grant, last_grant_n;
   logic                 we_q, we_n;
   logic [ADDR_SIZE-1:0] addr_q, addr_n;
   logic [7:0]           wdata_q, wdata_n;
   logic [7:0]           rdata0_n, rdata1_n;
   logic                 ack0_n, ack1_n, rx_valid_n;
   logic [DIN_W-1:0]     din_n;
`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic                 err_n;
`endif

   // Outputs are computed for the state being entered, so after the register they line up with it.
   always_comb begin
      next_state   = state;
      grant_n      = grant;
      last_grant_n = last_grant;
      we_n         = we_q;
      addr_n       = addr_q;
      wdata_n      = wdata_q;
      rdata0_n     = rdata0;
      rdata1_n     = rdata1;
      ack0_n       = 1'b0;
      ack1_n       = 1'b0;
      rx_valid_n   = 1'b0;
      din_n        = ram_din;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_n        = cnt;
      err_n        = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // last_grant only moves on a tie, so requester 0 wins the first tie after reset
               if (req0 && req1) begin
                  grant_n      = ~last_grant;
                  last_grant_n = ~last_grant;
               end else begin
                  grant_n = req1;
               end
               we_n       = grant_n ? we1 : we0;
               addr_n     = grant_n ? addr1 : addr0;
               wdata_n    = grant_n ? wdata1 : wdata0;
               rx_valid_n = 1'b1;
               if (we_n) begin
                  next_state = WR_ADDR;
                  din_n      = {2'b00, addr_n};
               end else begin
                  next_state = RD_ADDR;
                  din_n      = {2'b10, addr_n};
               end
            end
         end
         WR_ADDR: begin
            next_state = WR_DATA;
            rx_valid_n = 1'b1;
            din_n      = {2'b01, ADDR_SIZE'(wdata_q)};
         end
         WR_DATA: begin
            next_state = DONE;
            ack0_n     = ~grant;
            ack1_n     = grant;
         end
         RD_ADDR: begin
            next_state = RD_DATA;
            rx_valid_n = 1'b1;
            din_n      = {2'b11, {ADDR_SIZE{1'b0}}};
         end
         RD_DATA: begin
            next_state = RD_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt_n      = '0;
`endif
         end
         RD_WAIT: begin
            if (ram_tx_valid) begin
               next_state = DONE;
               ack0_n     = ~grant;
               ack1_n     = grant;
               if (grant) rdata1_n = ram_dout;
               else       rdata0_n = ram_dout;
            end
`ifdef RAM_ARB_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               next_state = DONE;
               ack0_n     = ~grant;
               ack1_n     = grant;
               err_n      = 1'b1;
               if (grant) rdata1_n = 8'hFF;
               else       rdata0_n = 8'hFF;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
         ram_rx_valid <= 1'b0;
         ram_din      <= '0;
         busy         <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
         cnt          <= '0;
         err          <= 1'b0;
`endif
      end else begin
         state        <= next_state;
         grant        <= grant_n;
         last_grant   <= last_grant_n;
         we_q         <= we_n;
         addr_q       <= addr_n;
         wdata_q      <= wdata_n;
         ack0         <= ack0_n;
         ack1         <= ack1_n;
         rdata0       <= rdata0_n;
         rdata1       <= rdata1_n;
         ram_rx_valid <= rx_valid_n;
         ram_din      <= din_n;
         busy         <= (next_state != IDLE);
`ifdef RAM_ARB_TIMEOUT_EN
         cnt          <= cnt_n;
         err          <= err_n;
`endif
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a transaction-level model predicts grant order,
// RAM command words, ack cycle and rdata; monitors compare against what the DUT presents.
module tb_ram_port_arbiter;

   localparam int ADDR_SIZE = 8;
   localparam int TIMEOUT   = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, ram_rx_valid, busy;
   logic [7:0] rdata0, rdata1;
   logic [9:0] ram_din;
   logic       ram_tx_valid = 1'b0;
   logic [7:0] ram_dout = '0;
`ifdef RAM_ARB_TIMEOUT_EN
   logic       err;
`endif

   ram_port_arbiter #(.ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
      .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
      .busy(busy)
`ifdef RAM_ARB_TIMEOUT_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         who;
      logic [7:0] rdata;
      int         cyc;
      bit         err;
   } exp_t;

   exp_t       expq[$];
   logic [9:0] cmdq[$];
   int         delayq[$];
   int         tests = 0;
   int         fails = 0;

   // Reference model state: arbitration history, memory contents, last read value per requester
   bit         last;
   logic [7:0] refmem[256];
   logic [7:0] lastrd[2];

   function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Transaction-level prediction of one granted transaction starting at cycle 'start'
   task automatic predict(input bit g, input bit w, input logic [7:0] a, input logic [7:0] v,
                          input int dl, inout int start);
      exp_t e;
      int   lat;
      e.who = g;
      e.err = 1'b0;
      if (w) begin
         cmdq.push_back({2'b00, a});
         cmdq.push_back({2'b01, v});
         refmem[a] = v;
         e.rdata   = lastrd[g];
         lat       = 3;
      end else begin
         cmdq.push_back({2'b10, a});
         cmdq.push_back(10'h300);
         delayq.push_back(dl);
         if (dl == 0) begin
            e.rdata = 8'hFF;
            e.err   = 1'b1;
            lat     = 3 + TIMEOUT;
         end else begin
            e.rdata = refmem[a];
            lat     = 3 + dl;
         end
         lastrd[g] = e.rdata;
      end
      e.cyc = start + lat - 1;
      start = start + lat + 1;
      expq.push_back(e);
   endtask

   // Behavioural RAM: decodes command words, answers reads after a scripted delay,
   // and throws spurious tx_valid pulses whenever no read is outstanding.
   bit         ramPend = 1'b0;
   int         ramCnt = 0;
   logic [7:0] ramAddr = '0;
   logic [7:0] mem[256];
   logic [9:0] ramCmd;
   int         ramDly;
   always @(negedge clk) begin
      if (!rst_n) begin
         ramPend      = 1'b0;
         ram_tx_valid = 1'b0;
      end else begin
         if (ramPend) begin
            ramCnt--;
            if (ramCnt == 0) begin
               ram_tx_valid = 1'b1;
               ram_dout     = mem[ramAddr];
               ramPend      = 1'b0;
            end else begin
               ram_tx_valid = 1'b0;
            end
         end else begin
            ram_tx_valid = ($urandom_range(0, 3) == 0);
            ram_dout     = 8'($urandom);
         end
         if (ram_rx_valid) begin
            if (cmdq.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL ram_cmd: got %0h, expected no command (cycle %0d)", ram_din, cyc);
            end else begin
               ramCmd = cmdq.pop_front();
               checkOutput("ram_cmd", ram_din, ramCmd);
            end
            case (ram_din[9:8])
               2'b00:   ramAddr = ram_din[7:0];
               2'b01:   mem[ramAddr] = ram_din[7:0];
               2'b10:   ramAddr = ram_din[7:0];
               default: begin
                  ramDly  = (delayq.size() != 0) ? delayq.pop_front() : 3;
                  ramPend = 1'b1;
                  ramCnt  = (ramDly == 0) ? 32'h4000_0000 : ramDly;
               end
            endcase
         end
      end
   end

   // Ack monitor: every ack pops the next predicted completion
   exp_t mon;
   always @(negedge clk) begin
      if (rst_n && (ack0 || ack1)) begin
         if (ack0 && ack1) begin
            tests++;
            fails++;
            $display("[TB] FAIL dual_ack: got both acks, expected one (cycle %0d)", cyc);
         end
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none (cycle %0d)",
                     ack0, ack1, cyc);
         end else begin
            mon = expq.pop_front();
            checkOutput("ack_who", {31'd0, ack1}, {31'd0, mon.who});
            checkOutput("ack_cycle", cyc, mon.cyc);
            checkOutput("ack_rdata", mon.who ? rdata1 : rdata0, mon.rdata);
`ifdef RAM_ARB_TIMEOUT_EN
            checkOutput("ack_err", {31'd0, err}, {31'd0, mon.err});
`endif
         end
      end
   end

   task automatic finishRound();
      @(negedge clk);
      checkOutput("busy_idle", {31'd0, busy}, 0);
      checkOutput("scoreboard_drained", expq.size(), 0);
   endtask

   task automatic flushOnHang(string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: got no completion, expected ack within budget (cycle %0d)", name, cyc);
      req0 = 1'b0;
      req1 = 1'b0;
      expq.delete();
      cmdq.delete();
      delayq.delete();
   endtask

   // One request from either or both requesters; each drops its req on its ack
   task automatic applyStimulus(input bit r0, input bit r1, input bit w0, input bit w1,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] v0, input logic [7:0] v1,
                                input int dl0, input int dl1);
      int start;
      bit first;
      int budget;
      @(negedge clk);
      we0 = w0; addr0 = a0; wdata0 = v0;
      we1 = w1; addr1 = a1; wdata1 = v1;
      req0 = r0; req1 = r1;
      start = cyc + 1;
      if (r0 && r1) begin
         first = ~last;
         last  = first;
      end else begin
         first = r1;
      end
      if (first) predict(1'b1, w1, a1, v1, dl1, start);
      else       predict(1'b0, w0, a0, v0, dl0, start);
      if (r0 && r1) begin
         if (first) predict(1'b0, w0, a0, v0, dl0, start);
         else       predict(1'b1, w1, a1, v1, dl1, start);
      end
      budget = 200;
      while ((req0 || req1) && budget > 0) begin
         @(negedge clk);
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
         budget--;
      end
      if (req0 || req1) flushOnHang("wait_ack");
      finishRound();
   endtask

   // Both requesters hold req continuously for four write transactions
   task automatic contention();
      logic [7:0] ca[2][2];
      logic [7:0] cv[2][2];
      int         k[2];
      int         mk[2];
      int         start;
      int         acks;
      int         budget;
      bit         g;
      for (int r = 0; r < 2; r++)
         for (int j = 0; j < 2; j++) begin
            ca[r][j] = 8'($urandom_range(8, 15));
            cv[r][j] = 8'($urandom);
         end
      @(negedge clk);
      we0 = 1'b1; addr0 = ca[0][0]; wdata0 = cv[0][0];
      we1 = 1'b1; addr1 = ca[1][0]; wdata1 = cv[1][0];
      req0 = 1'b1; req1 = 1'b1;
      k  = '{0, 0};
      mk = '{0, 0};
      start = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         g    = ~last;
         last = g;
         predict(g, 1'b1, ca[g][mk[g]], cv[g][mk[g]], 0, start);
         mk[g]++;
      end
      acks   = 0;
      budget = 200;
      while (acks < 4 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (ack0 || ack1) begin
            acks++;
            if (acks == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end else if (ack0) begin
               k[0]++;
               if (k[0] < 2) begin addr0 = ca[0][k[0]]; wdata0 = cv[0][k[0]]; end
            end else begin
               k[1]++;
               if (k[1] < 2) begin addr1 = ca[1][k[1]]; wdata1 = cv[1][k[1]]; end
            end
         end
      end
      if (acks < 4) flushOnHang("contention_ack");
      finishRound();
   endtask

   task automatic checkResetOutputs(string tag);
      checkOutput({tag, "_ack0"}, {31'd0, ack0}, 0);
      checkOutput({tag, "_ack1"}, {31'd0, ack1}, 0);
      checkOutput({tag, "_rdata0"}, rdata0, 0);
      checkOutput({tag, "_rdata1"}, rdata1, 0);
      checkOutput({tag, "_rx_valid"}, {31'd0, ram_rx_valid}, 0);
      checkOutput({tag, "_din"}, ram_din, 0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
`ifdef RAM_ARB_TIMEOUT_EN
      checkOutput({tag, "_err"}, {31'd0, err}, 0);
`endif
   endtask

   initial begin
      bit [1:0] rr;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = '0;
         refmem[i] = '0;
      end
      last   = 1'b1;
      lastrd = '{8'h00, 8'h00};

      // Reset held with a pending request
      rst_n = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'hA5;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      req0  = 1'b0;
      rst_n = 1'b1;

      // First tie after reset goes to requester 0
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h11, 8'h5A, 8'hC3, 2, 2);

      // Directed write then read-back through the other port
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 8'h00, 2, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h00, 8'h00, 2, 2);

      contention();
      contention();

      for (int n = 0; n < 40; n++) begin
         rr = 2'($urandom_range(1, 3));
         applyStimulus(rr[0], rr[1], 1'($urandom), 1'($urandom),
                       8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                       8'($urandom), 8'($urandom),
                       $urandom_range(2, 5), $urandom_range(2, 5));
      end

      // Reset while a read sits in RD_WAIT
      @(negedge clk);
      we0 = 1'b0; addr0 = 8'h3C; req0 = 1'b1;
      cmdq.push_back(10'h23C);
      cmdq.push_back(10'h300);
      delayq.push_back(40);
      repeat (3) @(negedge clk);
      checkOutput("busy_rd_wait", {31'd0, busy}, 1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("mid_read");
      checkOutput("mid_read_cmds_sent", cmdq.size(), 0);
      req0 = 1'b0;
      last = 1'b1;
      lastrd = '{8'h00, 8'h00};
      delayq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("no_ack_after_reset", {30'd0, ack0, ack1}, 0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 3, 3);

      for (int n = 0; n < 10; n++) begin
         rr = 2'($urandom_range(1, 3));
         applyStimulus(rr[0], rr[1], 1'($urandom), 1'($urandom),
                       8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                       8'($urandom), 8'($urandom),
                       $urandom_range(2, 5), $urandom_range(2, 5));
      end

`ifdef RAM_ARB_TIMEOUT_EN
      // RAM never answers: the read must time out with rdata=8'hFF and err
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
